// File: rtl/dpfifo_pkg.sv
// Shared constants for the dual-port-memory FIFO controller.
// Defaults describe the ADDR_SIZE=4 build; modules derive their own sizes from parameters.
package dpfifo_pkg;
  localparam int DEF_ADDR_SIZE = 4;
  localparam int DEPTH         = 2 ** DEF_ADDR_SIZE;
  localparam int PTR_W         = DEF_ADDR_SIZE + 1;
  localparam int OCC_W         = DEF_ADDR_SIZE + 2;
  localparam int BUF_DEPTH     = 2;
  localparam int CNT_W         = 2;
endpackage

// File: rtl/dpfifo_out_buf.sv
// 2-entry register FIFO that holds words returned by the memory and presents
// the head word first-word-fall-through to the consumer.
module dpfifo_out_buf import dpfifo_pkg::*; #(
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd,
  output logic [CNT_W-1:0]     buf_cnt,
  output logic [DATA_SIZE-1:0] head_data,
  output logic                 head_valid
);
  logic [DATA_SIZE-1:0] d0, d1;

  assign head_data  = d0;
  assign head_valid = (buf_cnt != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d0      <= '0;
      d1      <= '0;
      buf_cnt <= '0;
    end else begin
      buf_cnt <= buf_cnt + CNT_W'(wr) - CNT_W'(rd);
      // d0 is always the head; d1 only holds a second word when two are queued
      if (wr && rd) begin
        if (buf_cnt == CNT_W'(BUF_DEPTH)) begin
          d0 <= d1;
          d1 <= wr_data;
        end else begin
          d0 <= wr_data;
        end
      end else if (wr) begin
        if (buf_cnt == '0) d0 <= wr_data;
        else               d1 <= wr_data;
      end else if (rd) begin
        d0 <= d1;
      end
    end
  end
endmodule

// File: rtl/dpmem_fifo_ctrl.sv
// Valid/ready FIFO controller around an external simple dual-port memory (1-cycle read).
// Optional almost_full/almost_empty flags when DPFIFO_ALMOST_FLAGS_EN is defined.
module dpmem_fifo_ctrl import dpfifo_pkg::*; #(
  parameter int DATA_SIZE = 16,
  parameter int ADDR_SIZE = 4
`ifdef DPFIFO_ALMOST_FLAGS_EN
  ,
  parameter int AF_LEVEL  = (2 ** ADDR_SIZE) - 2,
  parameter int AE_LEVEL  = 2
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_SIZE-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 mem_wr_en,
  output logic [ADDR_SIZE-1:0] mem_wr_adr,
  output logic [DATA_SIZE-1:0] mem_dat_in,
  output logic [ADDR_SIZE-1:0] mem_rd_adr,
  input  logic [DATA_SIZE-1:0] mem_dat_out,
  output logic [ADDR_SIZE+1:0] occ
`ifdef DPFIFO_ALMOST_FLAGS_EN
  ,
  output logic                 almost_full,
  output logic                 almost_empty
`endif
);
  localparam int MDEPTH = 2 ** ADDR_SIZE;
  localparam int PW     = ADDR_SIZE + 1;
  localparam int OW     = ADDR_SIZE + 2;

  logic [PW-1:0]    wr_ptr, rd_ptr, mem_cnt;
  logic             rd_pend, rdy_en, push, pop, rd;
  logic [CNT_W-1:0] buf_cnt;
  logic [OW-1:0]    occ_nxt;

  assign in_ready   = rdy_en && (mem_cnt != PW'(MDEPTH));
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign mem_wr_en  = push;
  assign mem_wr_adr = wr_ptr[ADDR_SIZE-1:0];
  assign mem_dat_in = in_data;
  assign mem_rd_adr = rd_ptr[ADDR_SIZE-1:0];

  // Issue a read only if the buffer will have room once the in-flight word lands
  assign rd = (mem_cnt != '0) &&
              (({1'b0, buf_cnt} + {2'b00, rd_pend}) < (3'(BUF_DEPTH) + {2'b00, pop}));

  // Every word moves between memory, in-flight and buffer; only push/pop change the total
  assign occ_nxt = occ + OW'(push) - OW'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      rd_pend <= 1'b0;
      rdy_en  <= 1'b0;
      occ     <= '0;
    end else begin
      rdy_en  <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (rd)   rd_ptr <= rd_ptr + 1'b1;
      mem_cnt <= mem_cnt + PW'(push) - PW'(rd);
      rd_pend <= rd;
      occ     <= occ_nxt;
    end
  end

`ifdef DPFIFO_ALMOST_FLAGS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (int'(occ_nxt) >= AF_LEVEL);
      almost_empty <= (int'(occ_nxt) <= AE_LEVEL);
    end
  end
`endif

  dpfifo_out_buf #(.DATA_SIZE(DATA_SIZE)) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .wr        (rd_pend),
    .wr_data   (mem_dat_out),
    .rd        (pop),
    .buf_cnt   (buf_cnt),
    .head_data (out_data),
    .head_valid(out_valid)
  );
endmodule

// File: tb/tb_dpmem_fifo_ctrl.sv
// Bench for dpmem_fifo_ctrl: behavioural dual-port memory plus a queue reference model.
module tb_dpmem_fifo_ctrl;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, out_valid, out_ready, mem_wr_en;
  logic [DW-1:0] in_data, out_data, mem_dat_in, mem_dat_out;
  logic [AW-1:0] mem_wr_adr, mem_rd_adr;
  logic [AW+1:0] occ;
`ifdef DPFIFO_ALMOST_FLAGS_EN
  logic          almost_full, almost_empty;
`endif

  always #5 clk = ~clk;

  dpmem_fifo_ctrl #(.DATA_SIZE(DW), .ADDR_SIZE(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_wr_en(mem_wr_en), .mem_wr_adr(mem_wr_adr), .mem_dat_in(mem_dat_in),
    .mem_rd_adr(mem_rd_adr), .mem_dat_out(mem_dat_out), .occ(occ)
`ifdef DPFIFO_ALMOST_FLAGS_EN
    , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
  );

  // Simple dual-port memory: registered read returns old data on a same-address write
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_adr] <= mem_dat_in;
    mem_dat_out <= mem[mem_rd_adr];
  end

  int            checks = 0, errors = 0;
  logic [DW-1:0] q[$];
  int            pops, max_occ;
  logic          last_ov;
  logic [DW-1:0] last_pop;

  // One clock: drive at negedge, judge handshakes against the model, check occupancy after the edge
  task automatic cycle(input logic iv, input logic [DW-1:0] id, input logic ordy,
                       output logic pu, output logic po);
    @(negedge clk);
    in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    pu = in_valid & in_ready;
    po = out_valid & out_ready;
    last_ov = out_valid;
    if (out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++; $display("FAIL spurious_valid out_data=%h model empty", out_data);
      end else if (out_data !== q[0]) begin
        errors++; $display("FAIL order got=%h exp=%h", out_data, q[0]);
      end
    end
    if (q.size() < 16) begin
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_low got=%b exp=1 words=%0d", in_ready, q.size()); end
    end
    if (q.size() >= 18) begin
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL in_ready_full got=%b exp=0 words=%0d", in_ready, q.size()); end
    end
    if (po) begin void'(q.pop_front()); pops++; last_pop = out_data; end
    if (pu) q.push_back(id);
    @(posedge clk); #1;
    checks++;
    if (int'(occ) != q.size()) begin errors++; $display("FAIL occ got=%0d exp=%0d", occ, q.size()); end
    if (int'(occ) > max_occ) max_occ = int'(occ);
`ifdef DPFIFO_ALMOST_FLAGS_EN
    checks++;
    if (almost_full !== (q.size() >= 14)) begin
      errors++; $display("FAIL almost_full got=%b exp=%b words=%0d", almost_full, q.size() >= 14, q.size());
    end
    checks++;
    if (almost_empty !== (q.size() <= 2)) begin
      errors++; $display("FAIL almost_empty got=%b exp=%b words=%0d", almost_empty, q.size() <= 2, q.size());
    end
`endif
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    reset = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, occ, in_ready, mem_wr_en, mem_wr_adr, mem_rd_adr} !== '0) begin
      errors++; $display("FAIL reset_outputs ov=%b od=%h occ=%0d ir=%b we=%b wa=%0d ra=%0d exp=all 0",
                         out_valid, out_data, occ, in_ready, mem_wr_en, mem_wr_adr, mem_rd_adr);
    end
`ifdef DPFIFO_ALMOST_FLAGS_EN
    checks++;
    if (almost_full !== 1'b0 || almost_empty !== 1'b1) begin
      errors++; $display("FAIL reset_flags af=%b ae=%b exp af=0 ae=1", almost_full, almost_empty);
    end
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_before_clk got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_clk got=%b exp=1", in_ready); end
    q.delete();
  endtask

  task automatic test_latency();
    logic pu, po;
    int lat = 0;
    do_reset();
    cycle(1'b1, 16'hA5A5, 1'b1, pu, po);
    checks++;
    if (pu !== 1'b1) begin errors++; $display("FAIL first_push got=%b exp=1", pu); end
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, '0, 1'b1, pu, po);
      if (last_ov && lat == 0) lat = k;
    end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL latency got=%0d exp=3", lat); end
    checks++;
    if (last_pop !== 16'hA5A5 || occ !== '0) begin
      errors++; $display("FAIL single_word got=%h occ=%0d exp=a5a5 occ=0", last_pop, occ);
    end
  endtask

  task automatic test_full();
    logic pu, po;
    int nxt = 1;
    do_reset();
    for (int k = 0; k < 30; k++) begin
      cycle(1'b1, DW'(nxt), 1'b0, pu, po);
      if (pu) nxt++;
    end
    checks++;
    if (nxt - 1 != 18 || int'(occ) != 18 || in_ready !== 1'b0) begin
      errors++; $display("FAIL fill accepted=%0d occ=%0d ir=%b exp 18 18 0", nxt - 1, occ, in_ready);
    end
    pops = 0;
    for (int k = 0; k < 60 && q.size() != 0; k++) cycle(1'b0, '0, 1'b1, pu, po);
    checks++;
    if (pops != 18 || last_pop !== 16'd18) begin
      errors++; $display("FAIL drain pops=%0d last=%0d exp 18 18", pops, last_pop);
    end
  endtask

  task automatic test_back_to_back();
    logic pu, po;
    int sent = 0, first = -1, last = -1;
    do_reset();
    pops = 0;
    for (int k = 0; k < 200 && pops < 64; k++) begin
      cycle(sent < 64, DW'(16'h1000 + sent), 1'b1, pu, po);
      if (pu) sent++;
      if (po) begin if (first < 0) first = k; last = k; end
    end
    checks++;
    if (pops != 64 || last - first != 63) begin
      errors++; $display("FAIL throughput pops=%0d span=%0d exp 64 63", pops, last - first);
    end
  endtask

  task automatic test_random();
    logic pu, po;
    int sent = 0;
    do_reset();
    pops = 0; max_occ = 0;
    for (int k = 0; k < 20000 && pops < 2000; k++) begin
      cycle((sent < 2000) && ($urandom_range(0, 1) == 1), DW'($urandom), $urandom_range(0, 1) == 1, pu, po);
      if (pu) sent++;
    end
    checks++;
    if (pops != 2000 || q.size() != 0) begin
      errors++; $display("FAIL random_count pops=%0d left=%0d exp 2000 0", pops, q.size());
    end
    checks++;
    if (max_occ > 18) begin errors++; $display("FAIL random_max_occ got=%0d exp<=18", max_occ); end
  endtask

  task automatic test_mid_reset();
    logic pu, po;
    do_reset();
    for (int k = 0; k < 40 && q.size() < 10; k++) cycle(1'b1, DW'(16'h7700 + k), 1'b0, pu, po);
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || occ !== '0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_reset ov=%b occ=%0d ir=%b exp 0 0 0", out_valid, occ, in_ready);
    end
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    pops = 0;
    cycle(1'b1, 16'hBEEF, 1'b0, pu, po);
    for (int k = 0; k < 10; k++) cycle(1'b0, '0, 1'b1, pu, po);
    checks++;
    if (pops != 1 || last_pop !== 16'hBEEF) begin
      errors++; $display("FAIL post_reset pops=%0d data=%h exp 1 beef", pops, last_pop);
    end
  endtask

`ifdef DPFIFO_ALMOST_FLAGS_EN
  task automatic test_flags();
    logic pu, po;
    do_reset();
    for (int k = 0; k < 25; k++) cycle(1'b1, DW'(k), 1'b0, pu, po);
    for (int k = 0; k < 30; k++) cycle(1'b0, '0, 1'b1, pu, po);
  endtask
`endif

  initial begin
    pops = 0; max_occ = 0; last_ov = 1'b0; last_pop = '0;
    test_reset();
    test_latency();
    test_full();
    test_back_to_back();
    test_random();
    test_mid_reset();
`ifdef DPFIFO_ALMOST_FLAGS_EN
    test_flags();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
